// File: rtl/bytes_to_bits_stream_pkg.sv
// Shared constants and types for the byte-string to bit-stream converters.
//   H_*     : geometry of the h polynomial path (1138 B -> 9100 b, 26 b/beat)
//   K_BYTES : byte length of the k packing path
//   state_t : converter FSM state
package bytes_to_bits_stream_pkg;

    localparam int H_BYTES = 1138;
    localparam int H_BITS  = 9100;
    localparam int H_CHUNK = 26;
    localparam int K_BYTES = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Width of a counter that must reach the value 'beats' itself,
    // because the count is held at BEATS after a finished pass.
    function automatic int beat_cnt_w(input int beats);
        return $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/bytes_to_bits_stream_if.sv
// Load / chunk-stream bundle of the converter.
//   in_valid/in_ready/in_bytes : load handshake and packed input bytes
//   replay                     : restream the retained vector
//   out_valid/out_ready        : chunk handshake
//   out_chunk/out_last         : current chunk, last-beat flag
//   out_vec                    : whole working vector
//   beat_cnt/loaded            : pass progress, replay eligibility
// master = producer/consumer side, slave = converter side.
interface bytes_to_bits_stream_if
    import bytes_to_bits_stream_pkg::*;
#(
    parameter int N_BYTES = H_BYTES,
    parameter int OUT_LEN = H_BITS,
    parameter int CHUNK   = H_CHUNK
);
    localparam int BEATS = OUT_LEN / CHUNK;
    localparam int CNT_W = beat_cnt_w(BEATS);

    logic                 in_valid;
    logic                 in_ready;
    logic [8*N_BYTES-1:0] in_bytes;
    logic                 replay;
    logic                 out_valid;
    logic                 out_ready;
    logic [CHUNK-1:0]     out_chunk;
    logic                 out_last;
    logic [OUT_LEN-1:0]   out_vec;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 loaded;

    modport master (
        output in_valid, in_bytes, replay, out_ready,
        input  in_ready, out_valid, out_chunk, out_last, out_vec, beat_cnt, loaded
    );

    modport slave (
        input  in_valid, in_bytes, replay, out_ready,
        output in_ready, out_valid, out_chunk, out_last, out_vec, beat_cnt, loaded
    );

endinterface

// File: rtl/bytes_to_bits_stream_byte_order_map.sv
// byte_order_map: combinational byte-order reversal, also used by the k path.
//   in_bytes  : byte i = in_bytes[8i+7:8i]
//   out_bytes : input byte i placed at byte N_BYTES-1-i (byte 0 goes on top)
module byte_order_map #(
    parameter int N_BYTES = 32
) (
    input  logic [8*N_BYTES-1:0] in_bytes,
    output logic [8*N_BYTES-1:0] out_bytes
);

    for (genvar i = 0; i < N_BYTES; i++) begin : g_byte
        assign out_bytes[8*N_BYTES-1-8*i -: 8] = in_bytes[8*i +: 8];
    end

endmodule

// File: rtl/bytes_to_bits_stream.sv
// bytes_to_bits_stream: loads a byte string, reverses its byte order, keeps
// the low OUT_LEN bits and streams them CHUNK bits per beat, lowest first.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low
//   bus  : load / stream bundle (slave side)
// ROTATE=1 rotates the vector so it is restored after a full pass and can be
// replayed; ROTATE=0 shifts in zeros and drops the data after one pass.
module bytes_to_bits_stream
    import bytes_to_bits_stream_pkg::*;
#(
    parameter int N_BYTES = H_BYTES,
    parameter int OUT_LEN = H_BITS,
    parameter int CHUNK   = H_CHUNK,
    parameter bit ROTATE  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    bytes_to_bits_stream_if.slave  bus
);

    localparam int BEATS = OUT_LEN / CHUNK;
    localparam int CNT_W = beat_cnt_w(BEATS);

    if (OUT_LEN < 1 || OUT_LEN > 8*N_BYTES) begin : g_bad_len
        $error("bytes_to_bits_stream: OUT_LEN %0d out of range 1..%0d", OUT_LEN, 8*N_BYTES);
    end
    if (CHUNK < 1 || (OUT_LEN % CHUNK) != 0) begin : g_bad_chunk
        $error("bytes_to_bits_stream: OUT_LEN %0d not a multiple of CHUNK %0d", OUT_LEN, CHUNK);
    end

    logic [8*N_BYTES-1:0] mapped;

    byte_order_map #(.N_BYTES(N_BYTES)) u_map (
        .in_bytes  (bus.in_bytes),
        .out_bytes (mapped)
    );

    // Bytes above OUT_LEN are deliberately discarded.
    if (OUT_LEN < 8*N_BYTES) begin : g_drop
        logic map_unused;
        assign map_unused = ^mapped[8*N_BYTES-1:OUT_LEN];
    end

    state_t             state, state_nxt;
    logic [OUT_LEN-1:0] vec, vec_nxt, vec_adv;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               loaded_q, loaded_nxt;
    logic               last;

    // Vector after one accepted beat.
    if (OUT_LEN == CHUNK) begin : g_single
        assign vec_adv = ROTATE ? vec : '0;
    end else begin : g_multi
        assign vec_adv = ROTATE ? {vec[CHUNK-1:0], vec[OUT_LEN-1:CHUNK]}
                                : {{CHUNK{1'b0}}, vec[OUT_LEN-1:CHUNK]};
    end

    assign last = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_nxt  = state;
        vec_nxt    = vec;
        cnt_nxt    = cnt;
        loaded_nxt = loaded_q;
        case (state)
            IDLE: begin
                // A load takes priority over a replay in the same cycle.
                if (bus.in_valid) begin
                    vec_nxt    = mapped[OUT_LEN-1:0];
                    cnt_nxt    = '0;
                    loaded_nxt = 1'b1;
                    state_nxt  = STREAM;
                end else if (bus.replay && loaded_q && ROTATE) begin
                    cnt_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    vec_nxt = vec_adv;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (last) begin
                        state_nxt = IDLE;
                        if (!ROTATE) loaded_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            vec      <= '0;
            cnt      <= '0;
            loaded_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            cnt      <= cnt_nxt;
            loaded_q <= loaded_nxt;
        end
    end

    // in_ready is masked by rst so no load is offered while in reset.
    assign bus.in_ready  = rst && (state == IDLE);
    assign bus.out_valid = (state == STREAM);
    assign bus.out_chunk = vec[CHUNK-1:0];
    assign bus.out_last  = (state == STREAM) && last;
    assign bus.out_vec   = vec;
    assign bus.beat_cnt  = cnt;
    assign bus.loaded    = loaded_q;

endmodule

// File: tb/tb_bytes_to_bits_stream.sv
module tb_bytes_to_bits_stream;
    import bytes_to_bits_stream_pkg::*;

    localparam int N0 = H_BYTES, L0 = H_BITS, C0 = H_CHUNK, B0 = L0 / C0;
    localparam int N1 = 4, L1 = 32, C1 = 8, B1 = L1 / C1;

    logic clk, rst;
    int   n_cmp = 0, n_err = 0;

    bytes_to_bits_stream_if #(.N_BYTES(N0), .OUT_LEN(L0), .CHUNK(C0)) b0 ();
    bytes_to_bits_stream_if #(.N_BYTES(N1), .OUT_LEN(L1), .CHUNK(C1)) b1 ();

    bytes_to_bits_stream #(.N_BYTES(N0), .OUT_LEN(L0), .CHUNK(C0), .ROTATE(1'b1)) u0 (
        .clk(clk), .rst(rst), .bus(b0));
    bytes_to_bits_stream #(.N_BYTES(N1), .OUT_LEN(L1), .CHUNK(C1), .ROTATE(1'b0)) u1 (
        .clk(clk), .rst(rst), .bus(b1));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // scoreboards
    logic [C0-1:0] q0[$];
    logic [C1-1:0] q1[$];
    int beat0 = 0, tot0 = 0, beat1 = 0, tot1 = 0;
    bit rnd_en = 0;

    logic [8*N0-1:0] data0, m0;

    // DUT0 monitor: pops on handshake, checks stall stability
    initial begin
        bit            stall = 0;
        logic [C0-1:0] held = '0;
        logic [C0-1:0] e;
        forever begin
            @(negedge clk);
            if (b0.out_valid) begin
                if (stall) chk("u0_stall_hold", b0.out_chunk, held);
                if (b0.out_ready) begin
                    stall = 0;
                    if (q0.size() == 0) chk("u0_q_underflow", 1, 0);
                    else begin
                        e = q0.pop_front();
                        chk("u0_chunk", b0.out_chunk, e);
                        chk("u0_last", b0.out_last, beat0 == B0 - 1);
                        chk("u0_beat_cnt", b0.beat_cnt, beat0);
                        tot0++;
                        beat0 = (beat0 == B0 - 1) ? 0 : beat0 + 1;
                    end
                end else begin
                    stall = 1;
                    held  = b0.out_chunk;
                end
            end else stall = 0;
        end
    end

    // DUT1 monitor
    initial begin
        logic [C1-1:0] e;
        forever begin
            @(negedge clk);
            if (b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) chk("u1_q_underflow", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("u1_chunk", b1.out_chunk, e);
                    chk("u1_last", b1.out_last, beat1 == B1 - 1);
                    tot1++;
                    beat1 = (beat1 == B1 - 1) ? 0 : beat1 + 1;
                end
            end
        end
    end

    // random backpressure on DUT0
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) b0.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push0();
        for (int k = 0; k < B0; k++) q0.push_back(m0[C0*k +: C0]);
    endtask

    task automatic load0();
        chk("u0_in_ready_pre", b0.in_ready, 1);
        b0.in_valid = 1;
        b0.in_bytes = data0;
        push0();
        @(posedge clk); #1;
        b0.in_valid = 0;
    endtask

    task automatic wait_idle0(input int budget);
        bit to = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!b0.out_valid && b0.in_ready) begin to = 0; break; end
        end
        chk("u0_idle_timeout", to, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle1(input int budget);
        bit to = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!b1.out_valid && b1.in_ready) begin to = 0; break; end
        end
        chk("u1_idle_timeout", to, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int  t;
        bit  to;
        rst = 0;
        b0.in_valid = 0; b0.in_bytes = '0; b0.replay = 0; b0.out_ready = 1;
        b1.in_valid = 0; b1.in_bytes = '0; b1.replay = 0; b1.out_ready = 1;
        for (int i = 0; i < N0; i++) data0[8*i +: 8] = 8'(i);
        for (int i = 0; i < N0; i++) m0[8*(N0-1-i) +: 8] = data0[8*i +: 8];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", b0.out_valid, 0);
        chk("rst_in_ready", b0.in_ready, 0);
        chk("rst_beat_cnt", b0.beat_cnt, 0);
        chk("rst_loaded", b0.loaded, 0);
        chk("rst_out_vec_zero", b0.out_vec == '0, 1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rel_in_ready", b0.in_ready, 1);
        @(posedge clk); #1;

        // T1 / T2: full throughput
        t = tot0;
        load0();
        @(negedge clk);
        chk("t1_first_chunk", b0.out_chunk, 26'h26F7071);
        chk("t1_last", b0.out_last, 0);
        chk("t1_beat_cnt", b0.beat_cnt, 0);
        chk("t1_in_ready", b0.in_ready, 0);
        wait_idle0(B0 + 20);
        chk("t2_beats", tot0 - t, B0);
        chk("t2_vec_restored", b0.out_vec == m0[L0-1:0], 1);
        chk("t2_loaded", b0.loaded, 1);
        chk("t2_q_empty", q0.size(), 0);

        // T3: random backpressure, same data
        t = tot0;
        rnd_en = 1;
        load0();
        wait_idle0(20 * B0);
        rnd_en = 0;
        b0.out_ready = 1;
        chk("t3_beats", tot0 - t, B0);
        chk("t3_q_empty", q0.size(), 0);

        // T4: replay without reload
        t = tot0;
        b0.replay = 1;
        push0();
        @(posedge clk); #1;
        b0.replay = 0;
        wait_idle0(B0 + 20);
        chk("t4_beats", tot0 - t, B0);
        chk("t4_vec_restored", b0.out_vec == m0[L0-1:0], 1);

        // T5: reset mid-stream
        load0();
        to = 1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (b0.beat_cnt == 100) begin to = 0; break; end
        end
        chk("t5_reach_100_timeout", to, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        q0.delete();
        beat0 = 0;
        @(negedge clk);
        chk("t5_out_valid", b0.out_valid, 0);
        chk("t5_beat_cnt", b0.beat_cnt, 0);
        chk("t5_loaded", b0.loaded, 0);
        chk("t5_in_ready", b0.in_ready, 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("t5_in_ready_rel", b0.in_ready, 1);
        @(posedge clk); #1;
        b0.replay = 1;
        @(posedge clk); #1;
        b0.replay = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_replay_unloaded", b0.out_valid, 0);
        end
        @(posedge clk); #1;

        // T6: non-circular small instance
        t = tot1;
        chk("t6_in_ready_pre", b1.in_ready, 1);
        b1.in_valid = 1;
        b1.in_bytes = 32'h04030201;
        q1.push_back(8'h04); q1.push_back(8'h03); q1.push_back(8'h02); q1.push_back(8'h01);
        @(posedge clk); #1;
        b1.in_valid = 0;
        wait_idle1(20);
        chk("t6_beats", tot1 - t, B1);
        chk("t6_out_vec", b1.out_vec, 32'h0);
        chk("t6_loaded", b1.loaded, 0);
        chk("t6_q_empty", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
